// File: rtl/window_averager.sv
// Sliding-window sum and floor average over the last WIN signed samples.
// Once the window is full, each accepted sample produces one out_valid strobe.
module window_averager #(
   parameter int DATA_W  = 4,
   parameter int WIN     = 4,
   parameter int LOG_WIN = 2,
   parameter int SUM_W   = DATA_W + LOG_WIN
) (
   input  logic              clk,
   input  logic              clear,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] a,
   input  logic              flush,
   output logic [SUM_W-1:0]  y_sum,
   output logic [DATA_W-1:0] y_avg,
   output logic              out_valid,
   output logic              full,
   output logic              o_dbg_state
);

   // Handshake: in_valid qualifies a for one cycle. There is no ready signal,
   // so every cycle with in_valid=1 (and no clear/flush) accepts a sample.
   // out_valid is a one-cycle strobe with no downstream backpressure.

   typedef enum logic {
      FILL = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam logic [LOG_WIN-1:0] CNT_MAX = LOG_WIN'(WIN - 1);

   state_t              r_state;
   state_t              w_state_next;
   logic [DATA_W-1:0]   r_win [WIN];
   logic [SUM_W-1:0]    r_sum;
   logic [LOG_WIN-1:0]  r_count;
   logic [SUM_W-1:0]    w_a_ext;
   logic [SUM_W-1:0]    w_old_ext;
   logic [SUM_W-1:0]    w_sum_next;
   logic                w_load;

   always_ff @(posedge clk) begin
      if (!clear) begin
         r_state <= FILL;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         FILL: begin
            if (flush) begin
               w_state_next = FILL;
            end else if (in_valid && (r_count == CNT_MAX)) begin
               w_state_next = RUN;
            end
         end
         RUN: begin
            if (flush) begin
               w_state_next = FILL;
            end
         end
         default: w_state_next = FILL;
      endcase
   end

   // While filling, the oldest slot is still zero from reset, but it is masked anyway.
   assign w_a_ext    = {{LOG_WIN{a[DATA_W-1]}}, a};
   assign w_old_ext  = (r_state == RUN) ?
                       {{LOG_WIN{r_win[WIN-1][DATA_W-1]}}, r_win[WIN-1]} : '0;
   assign w_sum_next = r_sum + w_a_ext - w_old_ext;
   assign w_load     = (r_state == RUN) || (r_count == CNT_MAX);

   always_ff @(posedge clk) begin
      if (!clear || flush) begin
         for (int i = 0; i < WIN; i++) begin
            r_win[i] <= '0;
         end
         r_sum     <= '0;
         r_count   <= '0;
         y_sum     <= '0;
         y_avg     <= '0;
         out_valid <= 1'b0;
      end else if (in_valid) begin
         for (int i = WIN - 1; i > 0; i--) begin
            r_win[i] <= r_win[i-1];
         end
         r_win[0] <= a;
         r_sum    <= w_sum_next;
         if (r_state == FILL) begin
            r_count <= r_count + LOG_WIN'(1);
         end
         if (w_load) begin
            y_sum     <= w_sum_next;
            // Upper DATA_W bits of the sum are the arithmetic shift by LOG_WIN (floor).
            y_avg     <= w_sum_next[SUM_W-1:LOG_WIN];
            out_valid <= 1'b1;
         end else begin
            out_valid <= 1'b0;
         end
      end else begin
         out_valid <= 1'b0;
      end
   end

   assign full        = (r_state == RUN);
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_window_averager.sv
// Bench for window_averager: directed scenarios with literal expectations plus
// random traffic checked every cycle against a queue-based window model.
module tb_window_averager;

   localparam int DATA_W  = 4;
   localparam int WIN     = 4;
   localparam int LOG_WIN = 2;
   localparam int SUM_W   = 6;

   logic              clk = 1'b0;
   logic              clear = 1'b0;
   logic              in_valid = 1'b0;
   logic              flush = 1'b0;
   logic [DATA_W-1:0] a = '0;
   logic [SUM_W-1:0]  y_sum;
   logic [DATA_W-1:0] y_avg;
   logic              out_valid;
   logic              full;
   logic              o_dbg_state;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;

   // reference model state
   int win_q[$];
   int m_sum  = 0;
   int m_avg  = 0;
   bit m_ov   = 1'b0;
   bit m_full = 1'b0;
   logic [SUM_W+DATA_W-1:0] exp_q[$];

   window_averager #(
      .DATA_W(DATA_W), .WIN(WIN), .LOG_WIN(LOG_WIN), .SUM_W(SUM_W)
   ) dut (
      .clk(clk), .clear(clear), .in_valid(in_valid), .a(a), .flush(flush),
      .y_sum(y_sum), .y_avg(y_avg), .out_valid(out_valid), .full(full),
      .o_dbg_state(o_dbg_state)
   );

   // clock / reset block
   always #5 clk = ~clk;

   function automatic int floor_div(int s);
      if (s >= 0) return s / WIN;
      return -((-s + WIN - 1) / WIN);
   endfunction

   task automatic check(string name, int got, int want);
      n_tests++;
      if (got != want) begin
         n_fail++;
         $display("FAIL %s: got %0d, want %0d (t=%0t)", name, got, want, $time);
      end
   endtask

   task automatic model_step(bit c, bit v, int s, bit f);
      if (!c || f) begin
         win_q.delete();
         m_sum  = 0;
         m_avg  = 0;
         m_ov   = 1'b0;
         m_full = 1'b0;
      end else if (v) begin
         win_q.push_back(s);
         if (win_q.size() > WIN) void'(win_q.pop_front());
         if (win_q.size() == WIN) begin
            m_sum = 0;
            foreach (win_q[i]) m_sum += win_q[i];
            m_avg  = floor_div(m_sum);
            m_ov   = 1'b1;
            m_full = 1'b1;
            exp_q.push_back({SUM_W'(m_sum), DATA_W'(m_avg)});
         end else begin
            m_ov = 1'b0;
         end
      end else begin
         m_ov = 1'b0;
      end
   endtask

   // driver: apply inputs for one cycle, advance the model at the edge
   task automatic drive(bit c, bit v, int s, bit f);
      clear    = c;
      in_valid = v;
      a        = DATA_W'(s);
      flush    = f;
      @(posedge clk);
      model_step(c, v, s, f);
      #1;
   endtask

   task automatic samp(int s);
      drive(1'b1, 1'b1, s, 1'b0);
   endtask

   function automatic int rnd_s();
      return int'($urandom_range(0, 15)) - 8;
   endfunction

   // scoreboard / compare process
   always @(negedge clk) begin
      if (chk_en) begin
         check("y_sum", int'($signed(y_sum)), m_sum);
         check("y_avg", int'($signed(y_avg)), m_avg);
         check("out_valid", int'(out_valid), int'(m_ov));
         check("full", int'(full), int'(m_full));
         check("dbg_state", int'(o_dbg_state), int'(m_full));
         if (out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
               check("strobe_expected", 1, 0);
            end else begin
               logic [SUM_W+DATA_W-1:0] e;
               e = exp_q.pop_front();
               check("strobe_result", int'({y_sum, y_avg}), int'(e));
            end
         end
      end
   end

   initial begin
      int t2[8];
      t2 = '{7, -6, 3, -4, 5, -2, 1, 0};

      // 1: reset with random a/in_valid
      drive(1'b0, 1'($urandom_range(0, 1)), rnd_s(), 1'b0);
      chk_en = 1'b1;
      drive(1'b0, 1'($urandom_range(0, 1)), rnd_s(), 1'b0);
      check("rst_y_sum", int'(y_sum), 0);
      check("rst_y_avg", int'(y_avg), 0);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_full", int'(full), 0);

      // 2: basic stream
      for (int i = 0; i < 8; i++) begin
         samp(t2[i]);
         if (i < 3) check("s2_no_strobe", int'(out_valid), 0);
         if (i == 3) begin
            check("s2_first_sum", int'($signed(y_sum)), 0);
            check("s2_first_ov", int'(out_valid), 1);
            check("s2_full", int'(full), 1);
         end
         if (i == 4) begin
            check("s2_sum_neg", int'($signed(y_sum)), -2);
            check("s2_avg_floor", int'($signed(y_avg)), -1);
         end
      end
      check("s2_last_sum", int'($signed(y_sum)), 4);
      check("s2_last_avg", int'($signed(y_avg)), 1);

      // 3: extremes
      drive(1'b1, 1'b0, 0, 1'b1);
      repeat (4) samp(-8);
      check("s3_min_sum", int'($signed(y_sum)), -32);
      check("s3_min_avg", int'($signed(y_avg)), -8);
      repeat (4) samp(7);
      check("s3_max_sum", int'($signed(y_sum)), 28);
      check("s3_max_avg", int'($signed(y_avg)), 7);

      // 4: gaps
      drive(1'b1, 1'b0, 0, 1'b1);
      samp(7);
      drive(1'b1, 1'b0, rnd_s(), 1'b0);
      samp(-6);
      drive(1'b1, 1'b0, rnd_s(), 1'b0);
      samp(3);
      drive(1'b1, 1'b0, rnd_s(), 1'b0);
      check("s4_gap_ov", int'(out_valid), 0);
      check("s4_gap_sum", int'(y_sum), 0);
      samp(-4);
      check("s4_ov", int'(out_valid), 1);
      check("s4_sum", int'($signed(y_sum)), 0);

      // 5: flush drops concurrent sample
      drive(1'b1, 1'b0, 0, 1'b1);
      repeat (4) samp(1);
      check("s5_pre_sum", int'(y_sum), 4);
      drive(1'b1, 1'b1, 5, 1'b1);
      check("s5_full", int'(full), 0);
      check("s5_sum", int'(y_sum), 0);
      check("s5_ov", int'(out_valid), 0);
      for (int i = 0; i < 4; i++) begin
         samp(2);
         if (i < 3) check("s5_refill_ov", int'(out_valid), 0);
      end
      check("s5_sum2", int'(y_sum), 8);
      check("s5_avg2", int'(y_avg), 2);

      // 6: reset mid-RUN
      repeat (4) samp(3);
      drive(1'b0, 1'b1, 5, 1'b0);
      check("s6_sum", int'(y_sum), 0);
      check("s6_avg", int'(y_avg), 0);
      check("s6_full", int'(full), 0);
      check("s6_ov", int'(out_valid), 0);
      for (int i = 0; i < 4; i++) begin
         samp(-1);
         check("s6_refill_ov", int'(out_valid), (i == 3) ? 1 : 0);
      end

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         drive(1'($urandom_range(0, 99) >= 2),
               1'($urandom_range(0, 99) < 75),
               rnd_s(),
               1'($urandom_range(0, 99) < 3));
      end

      @(negedge clk);
      chk_en = 1'b0;
      check("exp_q_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
